apb_mgr_arbiter: RTL

Round-robin arbiter that lets several APB managers share one APB subordinate port. Typical use: the zeroHETI core and a second manager (DMA or debug access) both reach the peripheral demux, which decodes to the UART and mtimer. The arbiter owns the SETUP/ACCESS sequencing on the shared port. A transfer timeout returns a slave error to the manager instead of hanging on an unresponsive peripheral.

---
 rtl/apb_mgr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/apb_mgr_arbiter.sv
// Round-robin arbiter sharing one APB subordinate port between NrMgrs APB managers.
// Latency: request seen in IDLE -> SETUP next cycle -> ACCESS after; 3 cycles/transfer with no wait states.
// Backpressure: losing managers see pready=0 and hold; subordinate waits stretch ACCESS up to the timeout.
module apb_mgr_arbiter #(
  parameter int NrMgrs        = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NrMgrs-1:0]                mgr_psel_i,
  input  logic [NrMgrs-1:0]                mgr_penable_i,
  input  logic [NrMgrs-1:0]                mgr_pwrite_i,
  input  logic [NrMgrs-1:0][AddrWidth-1:0] mgr_paddr_i,
  input  logic [NrMgrs-1:0][DataWidth-1:0] mgr_pwdata_i,
  output logic [DataWidth-1:0]             mgr_prdata_o,
  output logic [NrMgrs-1:0]                mgr_pready_o,
  output logic [NrMgrs-1:0]                mgr_pslverr_o,
  output logic                             sub_psel_o,
  output logic                             sub_penable_o,
  output logic                             sub_pwrite_o,
  output logic [AddrWidth-1:0]             sub_paddr_o,
  output logic [DataWidth-1:0]             sub_pwdata_o,
  input  logic [DataWidth-1:0]             sub_prdata_i,
  input  logic                             sub_pready_i,
  input  logic                             sub_pslverr_i
);

  localparam int GntW  = (NrMgrs > 1) ? $clog2(NrMgrs) : 1;
  localparam int TcntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  // Counter value seen in the last permitted ACCESS cycle.
  localparam logic [TcntW-1:0] TcntLast =
    (TimeoutCycles == 0) ? '0 : TcntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [GntW-1:0]   gnt_q, gnt_d;
  logic [GntW-1:0]   ptr_q, ptr_d;
  logic [TcntW-1:0]  tcnt_q, tcnt_d;

  logic [GntW-1:0]   winner;
  logic [GntW-1:0]   cand;
  logic              found;
  logic              timeout;

  // Managers drive penable for their own protocol; the arbiter sequences the shared port itself.
  logic unused_penable;
  assign unused_penable = ^mgr_penable_i;

  // The granted manager's command fields go straight through to the shared port.
  assign sub_pwrite_o = mgr_pwrite_i[gnt_q];
  assign sub_paddr_o  = mgr_paddr_i[gnt_q];
  assign sub_pwdata_o = mgr_pwdata_i[gnt_q];

  // Round-robin pick: first requester at or after ptr_q, wrapping past the top index.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NrMgrs; i++) begin
      cand = GntW'((int'(ptr_q) + i) % NrMgrs);
      if (!found && mgr_psel_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Transfer sequencing, completion routing and timeout detection.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    tcnt_d        = tcnt_q;
    timeout       = 1'b0;
    sub_psel_o    = 1'b0;
    sub_penable_o = 1'b0;
    mgr_pready_o  = '0;
    mgr_pslverr_o = '0;
    mgr_prdata_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (|mgr_psel_i) begin
          gnt_d   = winner;
          state_d = SETUP;
        end
      end
      SETUP: begin
        sub_psel_o = 1'b1;
        tcnt_d     = '0;
        state_d    = ACCESS;
      end
      ACCESS: begin
        sub_psel_o    = 1'b1;
        sub_penable_o = 1'b1;
        timeout       = (TimeoutCycles != 0) && !sub_pready_i && (tcnt_q == TcntLast);
        if (!sub_pready_i) begin
          tcnt_d = tcnt_q + 1'b1;
        end
        if (sub_pready_i || timeout) begin
          // A forced completion reports an error with zeroed read data.
          mgr_pready_o[gnt_q]  = 1'b1;
          mgr_pslverr_o[gnt_q] = sub_pready_i ? sub_pslverr_i : 1'b1;
          mgr_prdata_o         = sub_pready_i ? sub_prdata_i : '0;
          ptr_d                = GntW'((int'(gnt_q) + 1) % NrMgrs);
          state_d              = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant, priority pointer and timeout counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule
